// File: rtl/ntr_resp_tx.sv
// Cartridge-side NTR response transmitter: prefetches one byte from a valid/ready
// source and shifts it onto the data bus once per clk edge while cs1 is low.
module ntr_resp_tx #(
    parameter int          LEN_WIDTH = 15,
    parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs1,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic [7:0]           src_data,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic [7:0]           data_out,
    output logic                 data_oe,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun
);

    typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [LEN_WIDTH-1:0] remaining;
    logic [7:0]           hold;
    logic                 consume;
    logic                 more;

    assign consume  = (state == XFER) && !cs1;
    assign more     = remaining > LEN_WIDTH'(1);
    assign data_out = hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (length != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (src_valid) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (consume && !more) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        src_ready = (state == LOAD) || (consume && more);
        data_oe   = consume;
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

    // An underrun still burns a byte slot: the idle byte goes out and the count moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            hold      <= IDLE_BYTE;
            underrun  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= length;
                        underrun  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (src_valid) begin
                        hold <= src_data;
                    end
                end
                XFER: begin
                    if (consume) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (more) begin
                            if (src_valid) begin
                                hold <= src_data;
                            end else begin
                                hold     <= IDLE_BYTE;
                                underrun <= 1'b1;
                            end
                        end
                    end
                end
                DONE: hold <= IDLE_BYTE;
                default: hold <= IDLE_BYTE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntr_resp_tx.sv
// Randomized scoreboard bench for ntr_resp_tx: a per-transfer byte plan is turned
// into the expected bus stream, and a monitor checks every byte and done pulse.
module tb_ntr_resp_tx;

    localparam int LW = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cs1 = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] length = '0;
    logic [7:0]    src_data = 8'h00;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [7:0]    data_out;
    logic          data_oe;
    logic          busy;
    logic          done;
    logic          underrun;

    ntr_resp_tx #(.LEN_WIDTH(LW), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .cs1(cs1), .start(start), .length(length),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .data_out(data_out), .data_oe(data_oe), .busy(busy), .done(done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        bit under;
    } txn_t;

    int         n_checks = 0;
    int         n_pass = 0;
    txn_t       txn_q[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] src_bytes[$];
    bit         src_ok[$];
    int         fetch_idx = 0;
    int         fetch_cnt = 0;
    int         pause_pct = 0;
    bit         last_under = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string msg);
        n_checks++;
        $display("[TB] FAIL %s: %s", name, msg);
    endtask

    // Host side chip select: random pauses at the configured rate.
    initial begin
        forever begin
            @(posedge clk);
            #1 cs1 = ($urandom_range(0, 99) < pause_pct);
        end
    end

    // Byte source following the current plan; a slot advances whenever the
    // DUT takes a byte or (after the first) asks for one that is not there.
    initial begin
        bit rdy_s;
        bit vld_s;
        forever begin
            @(negedge clk);
            rdy_s = src_ready;
            vld_s = src_valid;
            @(posedge clk);
            if (rst_n && rdy_s && (vld_s || fetch_idx > 0)) begin
                fetch_idx++;
                fetch_cnt++;
            end
            #1;
            if (fetch_idx < src_bytes.size()) begin
                src_data  = src_bytes[fetch_idx];
                src_valid = (fetch_idx == 0) ? 1'($urandom_range(0, 1)) : src_ok[fetch_idx];
            end else begin
                src_data  = 8'($urandom);
                src_valid = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: compares presented bytes and completion against the scoreboard.
    initial begin
        int  seen = 0;
        bit  prev_oe = 1'b0;
        txn_t t;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen    = 0;
                prev_oe = 1'b0;
                continue;
            end
            if (data_oe) begin
                if (exp_bytes.size() == 0) begin
                    fail_now("extra_byte", $sformatf("byte 0x%0h driven with none expected", data_out));
                end else begin
                    e = exp_bytes.pop_front();
                    check("byte", data_out, e);
                    seen++;
                end
            end else if (busy && !done && txn_q.size() > 0 && seen > 0 &&
                         seen < txn_q[0].len && exp_bytes.size() > 0) begin
                check("pause_hold", data_out, exp_bytes[0]);
            end
            if (done) begin
                if (txn_q.size() == 0) begin
                    fail_now("extra_done", "done pulse with no transfer pending");
                end else begin
                    t = txn_q.pop_front();
                    check("done_count", seen, t.len);
                    check("done_fetches", fetch_cnt, t.len);
                    check("done_underrun", underrun, t.under);
                    if (t.len > 0) check("done_latency", prev_oe, 1);
                    last_under = t.under;
                    seen = 0;
                end
            end else if (txn_q.size() == 0) begin
                check("idle_busy", busy, 0);
                check("idle_underrun", underrun, last_under);
            end else if (busy && seen == 0) begin
                check("start_clears_underrun", underrun, 0);
            end
            prev_oe = data_oe;
        end
    end

    // Build a transfer plan, queue its expected stream and pulse start.
    task automatic start_txn(input int len, input int base, input int under_pct, input int bad_idx);
        txn_t t;
        logic [7:0] b[$];
        bit ok[$];
        t.len   = len;
        t.under = 1'b0;
        for (int i = 0; i < len; i++) begin
            b.push_back((base < 0) ? 8'($urandom) : 8'(base + i));
            ok.push_back(!((i == bad_idx) || ($urandom_range(0, 99) < under_pct)));
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < len; i++) begin
            if (i == 0 || ok[i]) exp_bytes.push_back(b[i]);
            else begin
                exp_bytes.push_back(8'hFF);
                t.under = 1'b1;
            end
        end
        txn_q.push_back(t);
        src_bytes = b;
        src_ok    = ok;
        fetch_idx = 0;
        fetch_cnt = 0;
        start  = 1'b1;
        length = LW'(len);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_data_out", data_out, 8'hFF);
        check("rst_data_oe", data_oe, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_underrun", underrun, 0);
        txn_q.delete();
        exp_bytes.delete();
        src_bytes.delete();
        src_ok.delete();
        fetch_idx  = 0;
        fetch_cnt  = 0;
        last_under = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_done(input int bound);
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (txn_q.size() == 0) break;
        end
        if (txn_q.size() != 0) begin
            fail_now("timeout", $sformatf("transfer not finished, %0d bytes left", exp_bytes.size()));
            do_reset();
        end
    endtask

    task automatic wait_bytes(input int n);
        int got = 0;
        for (int c = 0; c < 400 && got < n; c++) begin
            @(negedge clk);
            if (data_oe) got++;
        end
        if (got < n) fail_now("byte_wait", "bytes did not appear in time");
    endtask

    task automatic applyStimulus();
        pause_pct = 0;
        start_txn(8, 8'h10, 0, -1);
        wait_done(200);

        pause_pct = 30;
        start_txn(6, 8'hA0, 0, -1);
        wait_done(300);

        pause_pct = 0;
        start_txn(8, 8'h30, 0, 4);
        wait_done(200);
        start_txn(3, 8'h40, 0, -1);
        wait_done(200);

        start_txn(0, 0, 0, -1);
        wait_done(50);

        start_txn(1, 8'h5A, 0, -1);
        wait_done(50);

        pause_pct = 20;
        start_txn(10, -1, 0, -1);
        wait_bytes(2);
        @(posedge clk);
        #1 start = 1'b1;
        length = LW'(3);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(400);

        start_txn(12, -1, 0, -1);
        wait_bytes(3);
        do_reset();
        repeat (5) @(posedge clk);
        pause_pct = 0;
        start_txn(8, 8'h10, 0, -1);
        wait_done(200);

        for (int k = 0; k < 25; k++) begin
            pause_pct = $urandom_range(0, 40);
            start_txn($urandom_range(0, 20), -1, 10, -1);
            wait_done(2000);
        end
    endtask

    task automatic checkOutput();
        repeat (4) @(negedge clk);
        check("final_busy", busy, 0);
        check("final_queue", exp_bytes.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("init_data_out", data_out, 8'hFF);
        check("init_data_oe", data_oe, 0);
        check("init_src_ready", src_ready, 0);
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_underrun", underrun, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        applyStimulus();
        checkOutput();
        $finish;
    end

endmodule
